// File: rtl/fpu_lib.sv
// Shared half-precision FPU types and constants.
// Pure declarations: no latency, no flow control.
package fpu_lib;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] QNAN16   = 16'h7E00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic divByZero;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  typedef enum logic [1:0] {
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_DIV
  } fpuOp_t;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero count of the 14-bit pre-normalization significand.
// Purely combinational; an all-zero input reports 14.
module fp16_lzc (
  input  logic [13:0] i_val,
  output logic [3:0]  o_cnt
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 4'd14;
    for (int k = 0; k < 14; k++) begin
      if (i_val[k]) o_cnt = 4'(13 - k);
    end
  end

endmodule

// File: rtl/fpu_add_sub16.sv
// Registered binary16 add/sub with round-to-nearest-even, ZCNV codes and IEEE flags.
// One cycle latency, one operation per clock, no handshake or backpressure.
module fpu_add_sub16
  import fpu_lib::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          sub,
  input  fp16_t         fpuIn1,
  input  fp16_t         fpuIn2,
  input  fpuOp_t        op,
  output fp16_t         fpuOut,
  output condCode_t     condCodes,
  output opStatusFlag_t opStatusFlags
);

  localparam logic [4:0] EXP_ONES = 5'(EXP_MAX);

  fp16_t         w_a, w_b, w_lg, w_sm, w_res;
  condCode_t     w_cc;
  opStatusFlag_t w_fl;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_eff_add;
  logic [4:0]    w_el, w_es, w_diff, w_lim, w_sh;
  logic [13:0]   w_ext_l, w_ext_s, w_lost, w_aligned, w_norm;
  logic [14:0]   w_sum;
  logic [3:0]    w_lz;
  logic [6:0]    w_exp_n, w_exp_r;
  logic [11:0]   w_mant_r;
  logic [10:0]   w_mant_f;
  logic          w_rup, w_inexact, w_carry;
  logic          w_op_unused;

  fp16_t         r_out;
  condCode_t     r_cc;
  opStatusFlag_t r_fl;

  assign w_op_unused = ^op;

  // Operand decode, magnitude swap, alignment with G/R/S, significand add/sub.
  always_comb begin
    w_a      = fpuIn1;
    w_b      = fpuIn2;
    w_b.sign = fpuIn2.sign ^ sub;
    w_a_nan  = (w_a.exp == EXP_ONES) && (w_a.frac != '0);
    w_b_nan  = (w_b.exp == EXP_ONES) && (w_b.frac != '0);
    w_a_inf  = (w_a.exp == EXP_ONES) && (w_a.frac == '0);
    w_b_inf  = (w_b.exp == EXP_ONES) && (w_b.frac == '0);
    if (w_b[14:0] > w_a[14:0]) begin
      w_lg = w_b;
      w_sm = w_a;
    end else begin
      w_lg = w_a;
      w_sm = w_b;
    end
    w_el    = (w_lg.exp == '0) ? 5'd1 : w_lg.exp;
    w_es    = (w_sm.exp == '0) ? 5'd1 : w_sm.exp;
    w_diff  = w_el - w_es;
    w_ext_l = {(w_lg.exp != '0), w_lg.frac, 3'b000};
    w_ext_s = {(w_sm.exp != '0), w_sm.frac, 3'b000};
    w_lost  = '0;
    if (w_diff >= 5'd14) begin
      w_aligned = {13'd0, |w_ext_s};
    end else begin
      w_aligned    = w_ext_s >> w_diff;
      w_lost       = w_ext_s & ~(14'h3FFF << w_diff);
      w_aligned[0] = w_aligned[0] | (|w_lost);
    end
    w_eff_add = (w_lg.sign == w_sm.sign);
    w_sum     = w_eff_add ? ({1'b0, w_ext_l} + {1'b0, w_aligned})
                          : ({1'b0, w_ext_l} - {1'b0, w_aligned});
  end

  fp16_lzc u_lzc (
    .i_val (w_sum[13:0]),
    .o_cnt (w_lz)
  );

  // Normalize, round, then resolve specials in priority order.
  always_comb begin
    w_lim = w_el - 5'd1;
    w_sh  = ({1'b0, w_lz} > w_lim) ? w_lim : {1'b0, w_lz};
    if (w_sum[14]) begin
      w_norm  = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_exp_n = {2'b00, w_el} + 7'd1;
    end else begin
      w_norm  = w_sum[13:0] << w_sh;
      w_exp_n = {2'b00, w_el - w_sh};
    end
    w_inexact = |w_norm[2:0];
    w_rup     = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_mant_r  = {1'b0, w_norm[13:3]} + {11'd0, w_rup};
    if (w_mant_r[11]) begin
      w_mant_f = w_mant_r[11:1];
      w_exp_r  = w_exp_n + 7'd1;
    end else begin
      w_mant_f = w_mant_r[10:0];
      w_exp_r  = w_exp_n;
    end
    w_carry = w_eff_add & w_sum[14];

    w_res = '0;
    w_cc  = '0;
    w_fl  = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
      w_res        = QNAN16;
      w_fl.invalid = 1'b1;
      w_cc.v       = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_res  = w_a_inf ? w_a : w_b;
      w_cc.n = w_res.sign;
    end else if (w_sum == '0) begin
      w_res.sign = w_a.sign & w_b.sign;
      w_cc.z     = 1'b1;
      w_cc.n     = w_res.sign;
    end else if (w_exp_r >= 7'(EXP_MAX)) begin
      w_res         = {w_lg.sign, EXP_ONES, 10'd0};
      w_cc.c        = w_carry;
      w_cc.n        = w_lg.sign;
      w_cc.v        = 1'b1;
      w_fl.overflow = 1'b1;
      w_fl.inexact  = 1'b1;
    end else begin
      // A subnormal that rounds up to 0x400 picks up exponent field 1 here.
      w_res.sign     = w_lg.sign;
      w_res.exp      = w_mant_f[10] ? w_exp_r[4:0] : 5'd0;
      w_res.frac     = w_mant_f[9:0];
      w_cc.c         = w_carry;
      w_cc.n         = w_lg.sign;
      w_fl.underflow = (w_res.exp == '0) & w_inexact;
      w_fl.inexact   = w_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_cc  <= '0;
      r_fl  <= '0;
    end else begin
      r_out <= w_res;
      r_cc  <= w_cc;
      r_fl  <= w_fl;
    end
  end

  assign fpuOut        = r_out;
  assign condCodes     = r_cc;
  assign opStatusFlags = r_fl;

endmodule

// File: tb/tb_fpu_add_sub16.sv
// Bench for fpu_add_sub16: directed test-plan vectors plus randomized ops vs an exact-arithmetic model.
module tb_fpu_add_sub16;
  import fpu_lib::*;

  localparam logic [15:0] ONE = {1'b0, 5'(EXP_BIAS), 10'd0};

  logic        clk;
  logic        rst;
  logic        sub;
  logic [15:0] in1, in2;
  fpuOp_t      op_r;
  logic [15:0] fpuOut;
  logic [3:0]  condCodes;
  logic [4:0]  opStatusFlags;

  int n_checks = 0;
  int n_errors = 0;

  fpu_add_sub16 dut (
    .clk           (clk),
    .rst           (rst),
    .sub           (sub),
    .fpuIn1        (in1),
    .fpuIn2        (in2),
    .op            (op_r),
    .fpuOut        (fpuOut),
    .condCodes     (condCodes),
    .opStatusFlags (opStatusFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact value in units of 2^-24, rounded with RNE into binade quanta.
  function automatic logic [24:0] ref_model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic sa, sb, a_nan, b_nan, a_inf, b_inf, carry, inex, neg;
    int ea, eb, el, p, q, ef;
    longint va, vb, sum, mag, mant, rem, half;
    sa    = a[15];
    sb    = b[15] ^ s;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      return {16'h7E00, 4'b0001, 5'b10000};
    if (a_inf) return {sa, 15'h7C00, 2'b00, sa, 1'b0, 5'b00000};
    if (b_inf) return {sb, 15'h7C00, 2'b00, sb, 1'b0, 5'b00000};
    ea    = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    eb    = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
    va    = longint'({(a[14:10] != 5'd0), a[9:0]}) << (ea - 1);
    vb    = longint'({(b[14:10] != 5'd0), b[9:0]}) << (eb - 1);
    el    = (ea > eb) ? ea : eb;
    carry = (sa == sb) && ((va + vb) >= (longint'(2048) << (el - 1)));
    sum   = (sa ? -va : va) + (sb ? -vb : vb);
    if (sum == 0) begin
      neg = sa & sb;
      return {neg, 15'd0, 1'b1, 1'b0, neg, 1'b0, 5'b00000};
    end
    neg = (sum < 0);
    mag = neg ? -sum : sum;
    p = 0;
    for (int k = 0; k < 48; k++) if (mag[k]) p = k;
    q    = (p > 10) ? p - 10 : 0;
    mant = mag >> q;
    rem  = mag - (mant << q);
    inex = (rem != 0);
    if (q > 0) begin
      half = longint'(1) << (q - 1);
      if ((rem > half) || ((rem == half) && mant[0])) mant++;
    end
    if (mant == 2048) begin
      mant = 1024;
      q++;
    end
    ef = (mant >= 1024) ? q + 1 : 0;
    if (ef >= 31) return {neg, 15'h7C00, 1'b0, carry, neg, 1'b1, 5'b00101};
    return {neg, 5'(ef), mant[9:0], 1'b0, carry, neg, 1'b0, 3'b000, (ef == 0) && inex, inex};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input fpuOp_t o, input string tag);
    logic [24:0] e;
    @(negedge clk);
    in1  = a;
    in2  = b;
    sub  = s;
    op_r = o;
    e    = ref_model(a, b, s);
    @(posedge clk);
    #1;
    check_eq({tag, " out"}, fpuOut, e[24:9]);
    check_eq({tag, " cc"}, {12'd0, condCodes}, {12'd0, e[8:5]});
    check_eq({tag, " flags"}, {11'd0, opStatusFlags}, {11'd0, e[4:0]});
  endtask

  task automatic run_dir(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] x_out, input logic [4:0] x_fl, input string tag);
    run_op(a, b, s, FPU_ADD, tag);
    check_eq({tag, " out const"}, fpuOut, x_out);
    check_eq({tag, " flags const"}, {11'd0, opStatusFlags}, {11'd0, x_fl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    logic [4:0]  eb;
    rst  = 1'b1;
    sub  = 1'b0;
    in1  = 16'h0000;
    in2  = 16'h0000;
    op_r = FPU_ADD;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset out", fpuOut, 16'h0000);
    check_eq("reset cc", {12'd0, condCodes}, 16'h0000);
    check_eq("reset flags", {11'd0, opStatusFlags}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_dir(ONE,      ONE,      1'b0, 16'h4000, 5'b00000, "1+1");
    run_dir(ONE,      ONE,      1'b1, 16'h0000, 5'b00000, "1-1");
    run_dir(ONE,      16'h4000, 1'b1, 16'hBC00, 5'b00000, "1-2");
    run_dir(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b00101, "max+max");
    run_dir(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'b10000, "inf-inf");
    run_dir(16'hFC00, 16'h7C00, 1'b0, 16'h7E00, 5'b10000, "-inf+inf");
    run_dir(16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00000, "sub+sub");
    run_dir(ONE,      16'h0001, 1'b0, 16'h3C00, 5'b00001, "1+tiny");
    run_dir(ONE,      16'h1000, 1'b0, 16'h3C00, 5'b00001, "tie even");
    run_dir(ONE,      16'h1001, 1'b0, 16'h3C01, 5'b00001, "above tie");
    run_dir(16'h7C01, ONE,      1'b0, 16'h7E00, 5'b10000, "nan in");
    run_dir(16'h7C00, ONE,      1'b0, 16'h7C00, 5'b00000, "inf+1");
    run_dir(16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b00000, "-0+-0");
    run_dir(16'h8000, 16'h0000, 1'b1, 16'h8000, 5'b00000, "-0-+0");
    run_dir(16'h0400, 16'h0001, 1'b1, 16'h03FF, 5'b00000, "norm->sub");
    run_dir(16'h03FF, 16'h0001, 1'b0, 16'h0400, 5'b00000, "sub->norm");
    run_dir(16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 5'b00101, "round ovf");
    run_dir(16'h0001, 16'h0002, 1'b1, 16'h8001, 5'b00000, "neg sub");

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        b = 16'($urandom);
      end else begin
        eb = a[14:10] + 5'($urandom_range(0, 2)) - 5'd1;
        b  = {1'($urandom), eb, 10'($urandom)};
      end
      run_op(a, b, (i >= 20), fpuOp_t'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    for (int k = 0; k < 4; k++)
      run_op(16'h4000, 16'h3555, 1'b0, fpuOp_t'(k), $sformatf("op%0d", k));

    run_op(ONE, ONE, 1'b0, FPU_MUL, "pre-rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst out", fpuOut, 16'h0000);
    check_eq("midrst cc", {12'd0, condCodes}, 16'h0000);
    check_eq("midrst flags", {11'd0, opStatusFlags}, 16'h0000);
    in1 = 16'h4000;
    in2 = ONE;
    sub = 1'b0;
    @(posedge clk);
    #1;
    check_eq("held rst out", fpuOut, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post rst out", fpuOut, 16'h4200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_add_sub16.md
# fpu_add_sub16

Registered IEEE-754 binary16 adder/subtractor forming the add/sub datapath of the half-precision FPU. It takes two fp16 operands and a subtract select, and produces a correctly rounded result (round-to-nearest-even), ZCNV condition codes and IEEE status flags one clock after sampling. The FPU top level instantiates it and drives `op` for uniformity; this block ignores `op`.

## Interface
- No parameters; the format is fixed at binary16.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous active-high reset.
- `sub`  in  1  selects the operation: 0 = fpuIn1 + fpuIn2, 1 = fpuIn1 − fpuIn2.
- `fpuIn1`  in  16 (`fp16_t`)  first operand.
- `fpuIn2`  in  16 (`fp16_t`)  second operand.
- `op`  in  `fpuOp_t`  FPU opcode; unused here, and must not affect any output.
- `fpuOut`  out  16 (`fp16_t`)  rounded result.
- `condCodes`  out  4 (`condCode_t`)  condition codes {Z,C,N,V}.
- `opStatusFlags`  out  5 (`opStatusFlag_t`)  status flags {invalid, divByZero, overflow, underflow, inexact}.

## Operation
- `fp16_t` is a packed struct {sign[15], exp[14:10], frac[9:0]} with bias 15.
- Operand classes:
  - exp=0, frac≠0: subnormal, implicit bit 0, effective exponent 1.
  - exp=31, frac=0: infinity.
  - exp=31, frac≠0: NaN.
- Effective sign of operand 2 is `fpuIn2.sign ^ sub`.
- Datapath:
  - Swap the operands so the larger magnitude is first.
  - Align the smaller significand by a right shift of the exponent difference, keeping guard, round and sticky bits. A shift of 14 or more collapses the operand to sticky only.
  - Add the significands when the signs match, otherwise subtract them.
  - Normalize: right-shift by 1 on carry-out, otherwise left-shift by the leading-zero count. The left shift is bounded so the exponent never goes below 1; hitting that bound gives a subnormal result.
  - Round to nearest, ties to even. A rounding carry may bump the exponent.
- Special cases:
  - Any NaN input → canonical quiet NaN 16'h7E00, invalid=1.
  - ∞ + (−∞) in effective terms → 16'h7E00, invalid=1.
  - Otherwise an infinity input passes through with its effective sign.
  - Exact zero result → +0, except (−0)+(−0) → −0.
  - Exponent ≥31 after rounding → ±∞ (7C00/FC00), with overflow=1 and inexact=1.
- Flags:
  - inexact = any guard, round or sticky bit was set before rounding.
  - underflow = result is subnormal or zero AND inexact.
  - divByZero = 0 always.
- Condition codes:
  - Z = result is ±0.
  - N = result sign bit, forced to 0 for NaN.
  - C = significand carry-out during an effective addition.
  - V = result is ∞ from overflow, or NaN was produced.

## Timing
- The result, condCodes and opStatusFlags are computed combinationally from the inputs and registered at each rising `clk`. Latency is one cycle.
- A new operation can start every cycle, so throughput is 1 per clock.
- There is no handshake: the registered outputs always reflect the inputs sampled at the previous edge.
- While `rst`=1, independent of `clk`: fpuOut=16'h0000, condCodes=4'b0000, opStatusFlags=5'b0. Asserting reset mid-stream discards the in-flight result.
- The first edge after reset deasserts registers the current inputs.

## Structure
- Shared package `fpu_lib` holds: `fp16_t`, `condCode_t`, `opStatusFlag_t`, `fpuOp_t` (enum including FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV), and the constants EXP_BIAS=15, EXP_MAX=31 and QNAN16=16'h7E00.
- One sub-module is natural: `fp16_lzc`, a leading-zero counter for the 14-bit normalization path.
- Everything else lives in a single always_comb block plus one always_ff block.

## Test plan
- Add 3C00 + 3C00, sub=0 → 4000 next cycle; ZCNV=0000, flags=0.
- Sub 3C00 − 3C00, sub=1 → 0000; Z=1, flags=0. Then 3C00 − 4000 → BC00, N=1.
- Overflow: 7BFF + 7BFF → 7C00; V=1, overflow=1, inexact=1. Also 7C00 − 7C00 with sub=1 → 7E00, invalid=1, V=1.
- Subnormals and rounding:
  - 0001 + 0001 → 0002, no flags.
  - 3C00 + 0001 → 3C00, inexact=1.
  - Tie-to-even: 3C00 + 1000 → 3C00, inexact=1.
- Special propagation:
  - Any NaN operand (e.g. 7C01 + 3C00) → 7E00, invalid=1.
  - 7C00 + 3C00 → 7C00.
  - 8000 + 8000 → 8000, Z=1.
- Reset and `op` independence:
  - Assert `rst` between edges → all outputs 0 immediately.
  - Deassert → next edge shows the sum of the current inputs.
  - Randomized 20 adds and 20 subs checked against a reference model, with `op` toggled randomly, give identical results.
